// File: rtl/abs_diff_pkg.sv
// Shared types and constants for the abs_diff delta-coded link (encoder and reconstruction side).
package abs_diff_pkg;

    localparam int SAMPLE_W      = 8;
    localparam int MAG_W_DEFAULT = 9;

    typedef enum logic {
        NOKEY,
        RUN
    } recon_state_e;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        logic                     key;
        logic                     sign;
        logic [MAG_W_DEFAULT-1:0] mag;
    } delta_t;

endpackage

// File: rtl/abs_diff_recon_alu.sv
// Combinational delta application: magnitude masking, add/subtract, then clamp or wrap to 8 bits.
// Clamping is selected by defining ABS_DIFF_RECON_SAT_EN; otherwise the result wraps modulo 256.
module abs_diff_recon_alu
    import abs_diff_pkg::*;
#(
    parameter int MAG_W    = MAG_W_DEFAULT,
    parameter int LSB_DROP = 0
) (
    input  sample_t          pred,
    input  logic             sign,
    input  logic [MAG_W-1:0] mag,
    output sample_t          sample,
    output logic             sat
);

    localparam int S_W = MAG_W + 2;
    localparam logic [MAG_W-1:0] MAG_MASK = {MAG_W{1'b1}} << LSB_DROP;

    logic [MAG_W-1:0]      mag_m;
    logic signed [S_W-1:0] pred_ext;
    logic signed [S_W-1:0] mag_ext;
    logic signed [S_W-1:0] s;

    always_comb begin
        mag_m    = mag & MAG_MASK;
        pred_ext = $signed({{(S_W - SAMPLE_W){1'b0}}, pred});
        mag_ext  = $signed({2'b00, mag_m});
        s        = sign ? (pred_ext - mag_ext) : (pred_ext + mag_ext);
    end

`ifdef ABS_DIFF_RECON_SAT_EN
    localparam logic signed [S_W-1:0] SAMPLE_MAX = S_W'((1 << SAMPLE_W) - 1);

    always_comb begin
        sample = sample_t'(s);
        sat    = 1'b0;
        if (s < 0) begin
            sample = '0;
            sat    = 1'b1;
        end else if (s > SAMPLE_MAX) begin
            sample = '1;
            sat    = 1'b1;
        end
    end
`else
    always_comb begin
        sample = sample_t'(s);
        sat    = 1'b0;
    end
`endif

endmodule

// File: rtl/abs_diff_recon.sv
// Receive-side reconstruction of an 8-bit sample stream from key/delta tokens, one registered
// output stage with valid/ready. ABS_DIFF_RECON_SAT_EN selects clamping instead of wrap.
module abs_diff_recon
    import abs_diff_pkg::*;
#(
    parameter int MAG_W    = MAG_W_DEFAULT,
    parameter int LSB_DROP = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_key,
    input  logic             in_sign,
    input  logic [MAG_W-1:0] in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sat,
    output logic             err,
    output logic [CNT_W-1:0] run_cnt
);

    recon_state_e     state_q, state_d;
    sample_t          pred_q, pred_d;
    logic             out_valid_q, out_valid_d;
    sample_t          out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

    sample_t alu_sample;
    logic    alu_sat;
    logic    in_xfer;

    abs_diff_recon_alu #(
        .MAG_W   (MAG_W),
        .LSB_DROP(LSB_DROP)
    ) u_alu (
        .pred  (pred_q),
        .sign  (in_sign),
        .mag   (in_mag),
        .sample(alu_sample),
        .sat   (alu_sat)
    );

    // The output slot is free when empty or draining this cycle.
    assign in_ready = ~out_valid_q | out_ready;
    assign in_xfer  = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        err_d       = 1'b0;
        run_cnt_d   = run_cnt_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_xfer && in_key) begin
            pred_d      = in_mag[SAMPLE_W-1:0];
            out_data_d  = in_mag[SAMPLE_W-1:0];
            out_sat_d   = 1'b0;
            out_valid_d = 1'b1;
            run_cnt_d   = CNT_W'(1);
            state_d     = RUN;
        end else if (in_xfer) begin
            if (state_q == NOKEY) begin
                err_d = 1'b1;
            end else begin
                pred_d      = alu_sample;
                out_data_d  = alu_sample;
                out_sat_d   = alu_sat;
                out_valid_d = 1'b1;
                if (~&run_cnt_q) begin
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NOKEY;
            pred_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            err_q       <= 1'b0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            err_q       <= err_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign err       = err_q;
    assign run_cnt   = run_cnt_q;

endmodule

// File: tb/tb_abs_diff_recon.sv
// Directed bench for abs_diff_recon; a second instance (LSB_DROP=2, CNT_W=2) shares the inputs
// to cover magnitude masking and run-counter saturation.
module tb_abs_diff_recon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_key = 1'b0;
    logic        in_sign = 1'b0;
    logic [8:0]  in_mag = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_sat, err;
    logic [7:0]  out_data;
    logic [15:0] run_cnt;

    logic        in_ready_b, out_valid_b, out_sat_b, err_b;
    logic [7:0]  out_data_b;
    logic [1:0]  run_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    abs_diff_recon #(.MAG_W(9), .LSB_DROP(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .in_sign(in_sign), .in_mag(in_mag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .err(err), .run_cnt(run_cnt)
    );

    abs_diff_recon #(.MAG_W(9), .LSB_DROP(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_key(in_key),
        .in_sign(in_sign), .in_mag(in_mag), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_sat(out_sat_b), .err(err_b), .run_cnt(run_cnt_b)
    );

    task automatic reset_dut();
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic k, input logic s, input int m);
        in_valid = 1'b1;
        in_key = k;
        in_sign = s;
        in_mag = 9'(m);
        @(posedge clk); #1;
        $display("xfer key=%0b sign=%0b mag=%0d -> valid=%0b data=%0d sat=%0b err=%0b run=%0d",
                 k, s, m, out_valid, out_data, out_sat, err, run_cnt);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        checks++; if (run_cnt !== 16'd0) begin errors++; $display("FAIL reset_run_cnt got %0d want 0", run_cnt); end
        checks++; if ({err, out_sat} !== 2'b00) begin errors++; $display("FAIL reset_err_sat got %b want 00", {err, out_sat}); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_key();
        send(1'b1, 1'b0, 100);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL key_valid got %0b want 1", out_valid); end
        checks++; if (out_data !== 8'd100) begin errors++; $display("FAIL key_data got %0d want 100", out_data); end
        checks++; if (run_cnt !== 16'd1) begin errors++; $display("FAIL key_run got %0d want 1", run_cnt); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL key_sat got %0b want 0", out_sat); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL key_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_nokey();
        reset_dut();
        out_ready = 1'b0;
        send(1'b0, 1'b0, 5);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nokey_valid got %0b want 0", out_valid); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL nokey_err got %0b want 1", err); end
        idle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL nokey_err_pulse got %0b want 0", err); end
        out_ready = 1'b1;
        send(1'b1, 1'b0, 7);
        checks++; if (out_data !== 8'd7 || out_valid !== 1'b1) begin errors++; $display("FAIL nokey_key7 got %0d/%0b want 7/1", out_data, out_valid); end
        idle();
    endtask

    task automatic test_updown();
        reset_dut();
        send(1'b1, 1'b0, 100);
        checks++; if (out_data !== 8'd100 || run_cnt !== 16'd1) begin errors++; $display("FAIL ud0 got %0d/%0d want 100/1", out_data, run_cnt); end
        send(1'b0, 1'b0, 20);
        checks++; if (out_data !== 8'd120 || run_cnt !== 16'd2) begin errors++; $display("FAIL ud1 got %0d/%0d want 120/2", out_data, run_cnt); end
        checks++; if (run_cnt_b !== 2'd2) begin errors++; $display("FAIL ud1_run_b got %0d want 2", run_cnt_b); end
        send(1'b0, 1'b1, 50);
        checks++; if (out_data !== 8'd70 || run_cnt !== 16'd3) begin errors++; $display("FAIL ud2 got %0d/%0d want 70/3", out_data, run_cnt); end
        checks++; if (out_data_b !== 8'd72) begin errors++; $display("FAIL ud2_masked got %0d want 72", out_data_b); end
        send(1'b0, 1'b0, 0);
        checks++; if (out_data !== 8'd70 || run_cnt !== 16'd4 || out_valid !== 1'b1) begin errors++; $display("FAIL ud3 got %0d/%0d want 70/4", out_data, run_cnt); end
        checks++; if (run_cnt_b !== 2'd3) begin errors++; $display("FAIL ud3_run_b_sat got %0d want 3", run_cnt_b); end
        idle();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_hi, exp_lo;
        logic       exp_sat;
`ifdef ABS_DIFF_RECON_SAT_EN
        exp_hi = 8'd255; exp_lo = 8'd0; exp_sat = 1'b1;
`else
        exp_hi = 8'd4; exp_lo = 8'd250; exp_sat = 1'b0;
`endif
        reset_dut();
        send(1'b1, 1'b0, 250);
        send(1'b0, 1'b0, 10);
        checks++; if (out_data !== exp_hi || out_sat !== exp_sat) begin errors++; $display("FAIL ovf_up got %0d/%0b want %0d/%0b", out_data, out_sat, exp_hi, exp_sat); end
        send(1'b1, 1'b0, 3);
        checks++; if (out_data !== 8'd3 || out_sat !== 1'b0) begin errors++; $display("FAIL ovf_key3 got %0d/%0b want 3/0", out_data, out_sat); end
        send(1'b0, 1'b1, 9);
        checks++; if (out_data !== exp_lo || out_sat !== exp_sat) begin errors++; $display("FAIL ovf_dn got %0d/%0b want %0d/%0b", out_data, out_sat, exp_lo, exp_sat); end
        idle();
    endtask

    task automatic test_backpressure();
        reset_dut();
        send(1'b1, 1'b0, 10);
        send(1'b0, 1'b0, 1);
        in_valid = 1'b1; in_key = 1'b0; in_sign = 1'b0; in_mag = 9'd2;
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %0b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            $display("stall cycle %0d data=%0d run=%0d in_ready=%0b", i, out_data, run_cnt, in_ready);
            checks++; if (out_data !== 8'd11 || run_cnt !== 16'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_stall%0d got %0d/%0d/%0b/%0b want 11/2/1/0", i, out_data, run_cnt, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== 8'd13 || run_cnt !== 16'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_after got %0d/%0d want 13/3", out_data, run_cnt); end
        idle();
        checks++; if (out_valid !== 1'b0 || run_cnt !== 16'd3) begin errors++; $display("FAIL bp_no_dup got %0b/%0d want 0/3", out_valid, run_cnt); end
    endtask

    task automatic test_lsb_drop();
        reset_dut();
        send(1'b1, 1'b0, 40);
        checks++; if (out_data_b !== 8'd40) begin errors++; $display("FAIL lsb_key got %0d want 40", out_data_b); end
        send(1'b0, 1'b0, 7);
        checks++; if (out_data_b !== 8'd44) begin errors++; $display("FAIL lsb_delta got %0d want 44", out_data_b); end
        checks++; if (out_data !== 8'd47) begin errors++; $display("FAIL lsb_nodrop got %0d want 47", out_data); end
        send(1'b1, 1'b1, 9'h12B);
        checks++; if (out_data_b !== 8'd43 || out_data !== 8'd43) begin errors++; $display("FAIL lsb_key_unmasked got %0d/%0d want 43/43", out_data_b, out_data); end
        idle();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        send(1'b1, 1'b0, 9);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %0b want 1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'd0 || run_cnt !== 16'd0 || out_sat !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL mid_reset got v%0b d%0d r%0d s%0b e%0b want all 0", out_valid, out_data, run_cnt, out_sat, err);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %0b want 1", in_ready); end
        rst = 1'b0;
        out_ready = 1'b1;
        send(1'b0, 1'b0, 1);
        checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_state_nokey got e%0b v%0b want 1/0", err, out_valid); end
        idle();
    endtask

    initial begin
        test_reset();
        test_key();
        test_nokey();
        test_updown();
        test_overflow();
        test_backpressure();
        test_lsb_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/abs_diff_recon.md
# abs_diff_recon

Streaming decoder that rebuilds an 8-bit unsigned sample stream from sign/magnitude deltas produced by the `abs_diff` datapath (9-bit |a−b| plus a direction bit). It sits on the receive side of the delta-coded link. It holds the running predictor, applies each delta to produce the next sample, and hands samples downstream over a valid/ready handshake with one registered stage.

## Interface
Parameters:
- `MAG_W`, 9: width of the incoming magnitude; matches the `abs_diff` output width.
- `LSB_DROP`, 0: number of magnitude LSBs forced to zero before use. This mirrors the approximate encoder, whose low result bits are constant 0. Legal range 0..4.
- `CNT_W`, 16: width of the run counter.

Ports (all names fixed; clock and reset first):
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `in_valid` input 1: input token present.
- `in_ready` output 1: decoder accepts the token this cycle.
- `in_key` input 1: token is an absolute sample; `in_mag[7:0]` is loaded directly.
- `in_sign` input 1: delta direction. 1 = sample decreases (prev − mag); 0 = sample increases (prev + mag).
- `in_mag` input MAG_W: delta magnitude, or the key sample in bits [7:0].
- `out_valid` output 1: reconstructed sample present.
- `out_ready` input 1: downstream accepts the sample.
- `out_data` output 8: reconstructed sample.
- `out_sat` output 1: `out_data` was clamped. Always 0 without the configuration macro.
- `err` output 1: one-cycle pulse when a delta is consumed before any key.
- `run_cnt` output CNT_W: samples emitted since the last key; saturates at all-ones.

## Operation
- **Transfer rules.** An input transfer occurs when `in_valid & in_ready`. An output transfer occurs when `out_valid & out_ready`.
- **Ready.** `in_ready = ~out_valid | out_ready`. The output register can take a new token in the same cycle the old one drains.
- **Magnitude masking.** `m = in_mag` with bits [LSB_DROP-1:0] cleared.
- **State machine, two states:**
  - NOKEY (reset state):
    - Key transfer: load the predictor with `in_mag[7:0]`, emit it, move to RUN.
    - Delta transfer: consume it, emit nothing, pulse `err` the following cycle, stay in NOKEY.
  - RUN:
    - Key transfer: reload as above, stay in RUN.
    - Delta transfer: compute the signed (MAG_W+2)-bit result `s = {0,pred} ± m`. Compute the sample from `s`, update the predictor to that sample, and emit it.
- **Predictor.** Equals the last emitted sample. It updates on input transfer, not output transfer.
- **Run counter.**
  - A key transfer sets `run_cnt` to 1.
  - Each emitted delta sample increments it. It holds at 2^CNT_W−1.
- **Key magnitude.** On a key, `in_sign` and `in_mag[MAG_W-1:8]` are ignored. Masking does not apply to keys.
- **Idle input.** `in_valid` low leaves all state unchanged.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_sat`=0, `err`=0, `run_cnt`=0, predictor=0, state NOKEY.
- **Reset response.** `in_ready` is 1 while `rst` is high and immediately after it. Reset asserted mid-stream discards the held output token without a handshake.
- **Latency.** Exactly 1 cycle from input transfer to `out_valid`. Back-to-back tokens sustain 1 sample/cycle while `out_ready` stays high.
- **Stall.** While `out_valid & ~out_ready`:
  - `out_data`, `out_sat` and `run_cnt` are stable.
  - `in_ready`=0.
- **Error pulse.** `err` is high for exactly one cycle per offending transfer, independent of `out_ready`.

## Configuration
- `ABS_DIFF_RECON_SAT_EN` defined: the sample is `s` clamped to 0..255, and `out_sat`=1 whenever clamping occurred. The predictor takes the clamped value.
- Not defined: the sample is `s[7:0]` (modulo-256 wrap), and `out_sat` is tied to 0.

## Structure
- **Package `abs_diff_pkg`:**
  - `SAMPLE_W`=8 and the default `MAG_W`=9.
  - State enum `recon_state_e` {NOKEY, RUN}.
  - Typedef `sample_t` (8-bit unsigned) and typedef `delta_t` (packed struct: key, sign, mag).
- **Sub-module `abs_diff_recon_alu`.** Combinational: masking, add/subtract and clamp/wrap. Outputs the sample and the sat flag. It is instantiated once; the FSM, registers and handshake stay in the top.

## Test plan
- **Reset then key:**
  - Stimulus: reset, then key `in_mag`=100.
  - Required response: `out_data`=100 one cycle later, `run_cnt`=1, `out_sat`=0.
- **Delta before key:**
  - Stimulus: after reset, delta sign=0 mag=5 with no key.
  - Required response: no `out_valid`, `err` pulses for 1 cycle; a following key 7 yields 7.
- **Up/down sequence:**
  - Stimulus: key 100, then (+20), (−50), (+0).
  - Required response: outputs 100, 120, 70, 70; `run_cnt` 1..4.
- **Overflow:**
  - Stimulus: key 250, then +10.
  - Required response with macro: 255, `out_sat`=1. Without macro: 4, `out_sat`=0.
  - Stimulus: key 3, then −9.
  - Required response: 0 with sat (macro), 250 without.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 3 cycles mid-stream.
  - Required response: `in_ready`=0 and `out_data` stable throughout; no token lost or duplicated after release.
- **LSB_DROP and reset mid-stream:**
  - Stimulus: LSB_DROP=2, key 40, then +7.
  - Required response: 44.
  - Stimulus: assert `rst` while `out_valid`=1.
  - Required response: all outputs at reset values on the next edge.
